regfile_write_buffer: RTL and testbench
=======================================

REGFILE_WRITE_BUFFER -- requirements
Module: regfile_write_buffer

Interface
REQ-001 The block SHALL have parameter n, default 32, meaning the data width of each buffered write.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of entries; legal values are only 2, 4 and 8.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  write request from the pipeline.
REQ-006 The block SHALL have port in_ready  output  1  buffer can accept a request this cycle.
REQ-007 The block SHALL have port in_rd  input  5  destination register index.
REQ-008 The block SHALL have port in_data  input  n  destination value.
REQ-009 The block SHALL have port drain_en  input  1  register file write port is available this cycle.
REQ-010 The block SHALL have port write  output  1  write strobe to the register file.
REQ-011 The block SHALL have port write_reg  output  5  register file write index.
REQ-012 The block SHALL have port write_data  output  n  register file write value.
REQ-013 The block SHALL have port fwd_addr1  input  5  first lookup index, from the register file read_reg1 path.
REQ-014 The block SHALL have port fwd_addr2  input  5  second lookup index, from the register file read_reg2 path.
REQ-015 The block SHALL have ports fwd_hit1 and fwd_hit2  output  1 each  a pending write matches the corresponding lookup index.
REQ-016 The block SHALL have ports fwd_data1 and fwd_data2  output  n each  value of the matching pending write.
REQ-017 The block SHALL have port occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-018 The block SHALL be a circular FIFO of {rd, data} entries with head and tail pointers that wrap modulo DEPTH.
REQ-019 A push SHALL occur on a rising edge when in_valid=1, in_ready=1 and in_rd!=0; it stores {in_rd, in_data} at the tail and advances the tail.
REQ-020 A handshake with in_rd=0 SHALL complete (it is consumed) but SHALL NOT store an entry or change occupancy.
REQ-021 in_ready SHALL equal (occupancy!=DEPTH); a full buffer SHALL deassert in_ready even if a pop occurs in the same cycle.
REQ-022 write SHALL equal drain_en AND (occupancy!=0); write_reg and write_data SHALL be driven combinationally from the head entry.
REQ-023 When write=1, the head SHALL advance on that rising edge, because the register file always accepts the write.
REQ-024 Write latency SHALL be one cycle minimum: an entry pushed at edge N can appear on write no earlier than the cycle after edge N.
REQ-025 A push and a pop in the same cycle SHALL both occur, and occupancy SHALL remain unchanged.
REQ-026 Writes SHALL leave the buffer in strict push order.
REQ-027 fwd_hitK SHALL be 1 when any valid entry has rd==fwd_addrK and fwd_addrK!=0; fwd_dataK SHALL then be the data of the youngest matching entry, and 0 otherwise.
REQ-028 Lookups SHALL be combinational over the stored entries only; a request being pushed in the same cycle SHALL NOT be visible to the lookup.
REQ-029 The head entry SHALL remain visible to lookups during its write cycle.
REQ-030 When write=0, write_reg and write_data SHALL be 0.

Reset
REQ-031 When rst=0, the block SHALL immediately clear head, tail and occupancy and invalidate all entries, independent of clk.
REQ-032 During and after reset: write=0, write_reg=0, write_data=0, fwd_hit1=fwd_hit2=0, fwd_data1=fwd_data2=0, occupancy=0, in_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all pending entries with no register file write issued for them.
REQ-034 The first push SHALL be accepted on the first rising edge after rst returns to 1.

Verification
REQ-035 Ordered drain: drain_en=0, push (5,0xA),(6,0xB),(5,0xC), then drain_en=1 -> three consecutive write cycles (5,0xA),(6,0xB),(5,0xC), then occupancy=0.
REQ-036 Forwarding priority: pending entries (5,0xA),(5,0xC), fwd_addr1=5, fwd_addr2=7 -> fwd_hit1=1 with fwd_data1=0xC, and fwd_hit2=0 with fwd_data2=0.
REQ-037 Full and wrap-around: drain_en=0, DEPTH+1 pushes -> in_ready=0 after the DEPTH-th push and the extra request is stalled; with drain_en=1 plus continuous pushes for 3*DEPTH cycles, no loss and order is preserved across pointer wrap.
REQ-038 x0 discard: push (0,0xFF) -> handshake completes, occupancy stays 0, write never asserts, fwd_addr1=0 gives fwd_hit1=0.
REQ-039 Simultaneous push and pop at occupancy=2 -> occupancy stays 2, and the written value is the older head entry.
REQ-040 Reset mid-stream: 3 entries pending, pulse rst low between clock edges -> all outputs go to reset values immediately, and no write occurs afterward until new pushes arrive.

Source files
------------

// File: rtl/regfile_write_buffer.sv
// ---------------------------------------------------------------------------
// regfile_write_buffer
//
// Circular FIFO that holds pending register file writes ({rd, data}).
// It drains its oldest entry into the register file whenever the write port
// is free. It also forwards the youngest pending value for two lookup
// indices, so that reads issued before the drain still see the new data.
//
// Parameters
//   n      : data width of each buffered write
//   DEPTH  : number of entries (2, 4 or 8)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   in_valid    in   write request from the pipeline
//   in_ready    out  buffer can accept a request this cycle (not full)
//   in_rd       in   destination register index (x0 requests are dropped)
//   in_data     in   destination value
//   drain_en    in   register file write port is free this cycle
//   write       out  write strobe to the register file
//   write_reg   out  write index (head entry, 0 when idle)
//   write_data  out  write value (head entry, 0 when idle)
//   fwd_addr1/2 in   lookup indices
//   fwd_hit1/2  out  a pending entry matches the lookup index
//   fwd_data1/2 out  data of the youngest matching entry, 0 on miss
//   occupancy   out  number of valid entries
//
// Handshake: a request transfers on a rising edge where in_valid=1 and
// in_ready=1. in_ready depends only on the registered occupancy, so a pop
// in the same cycle never frees a slot for a request while the buffer is full.
// ---------------------------------------------------------------------------
module regfile_write_buffer #(
   parameter int n     = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [4:0]                 in_rd,
   input  logic [n-1:0]               in_data,
   input  logic                       drain_en,
   output logic                       write,
   output logic [4:0]                 write_reg,
   output logic [n-1:0]               write_data,
   input  logic [4:0]                 fwd_addr1,
   input  logic [4:0]                 fwd_addr2,
   output logic                       fwd_hit1,
   output logic                       fwd_hit2,
   output logic [n-1:0]               fwd_data1,
   output logic [n-1:0]               fwd_data2,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [OW-1:0] occ_q, occ_d;
   logic [4:0]    rd_q   [DEPTH];
   logic [n-1:0]  data_q [DEPTH];

   logic push;
   logic pop;

   assign in_ready  = (occ_q != OW'(DEPTH));
   assign write     = drain_en && (occ_q != '0);
   assign occupancy = occ_q;

   // Writes to x0 complete the handshake but are never stored.
   assign push = in_valid && in_ready && (in_rd != 5'd0);
   assign pop  = write;

   assign write_reg  = write ? rd_q[head_q]   : 5'd0;
   assign write_data = write ? data_q[head_q] : '0;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      if (push) begin
         tail_d = tail_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= 5'd0;
            data_q[i] <= '0;
         end
      end else if (push) begin
         rd_q[tail_q]   <= in_rd;
         data_q[tail_q] <= in_data;
      end
   end

   // Walk the valid entries from oldest (head) to youngest. A later match
   // overwrites an earlier one, so the youngest matching value wins. Only
   // stored entries are searched, so a request arriving this cycle is not
   // visible. The head stays valid until the edge that retires it, so it is
   // also visible during its own write cycle.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (OW'(i) < occ_q) begin
            if ((fwd_addr1 != 5'd0) && (rd_q[head_q + PW'(i)] == fwd_addr1)) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = data_q[head_q + PW'(i)];
            end
            if ((fwd_addr2 != 5'd0) && (rd_q[head_q + PW'(i)] == fwd_addr2)) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = data_q[head_q + PW'(i)];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_buffer.sv
module tb_regfile_write_buffer;

   localparam int N     = 32;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_rd;
   logic [N-1:0]  in_data;
   logic          drain_en;
   logic          write;
   logic [4:0]    write_reg;
   logic [N-1:0]  write_data;
   logic [4:0]    fwd_addr1;
   logic [4:0]    fwd_addr2;
   logic          fwd_hit1;
   logic          fwd_hit2;
   logic [N-1:0]  fwd_data1;
   logic [N-1:0]  fwd_data2;
   logic [2:0]    occupancy;

   int n_checks = 0;
   int n_errors = 0;

   logic [36:0] exp_q[$];

   regfile_write_buffer #(.n(N), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rd      (in_rd),
      .in_data    (in_data),
      .drain_en   (drain_en),
      .write      (write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .fwd_addr1  (fwd_addr1),
      .fwd_addr2  (fwd_addr2),
      .fwd_hit1   (fwd_hit1),
      .fwd_hit2   (fwd_hit2),
      .fwd_data1  (fwd_data1),
      .fwd_data2  (fwd_data2),
      .occupancy  (occupancy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [4:0] rd, input logic [31:0] data);
      in_valid = 1'b1;
      in_rd    = rd;
      in_data  = data;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_write"},      write,      0);
      chk({tag, "_write_reg"},  write_reg,  0);
      chk({tag, "_write_data"}, write_data, 0);
      chk({tag, "_hit1"},       fwd_hit1,   0);
      chk({tag, "_hit2"},       fwd_hit2,   0);
      chk({tag, "_data1"},      fwd_data1,  0);
      chk({tag, "_data2"},      fwd_data2,  0);
      chk({tag, "_occ"},        occupancy,  0);
      chk({tag, "_in_ready"},   in_ready,   1);
   endtask

   initial begin
      int          m_occ;
      int          k;
      logic [4:0]  req_rd;
      logic [31:0] req_data;

      rst = 1'b0; in_valid = 1'b0; in_rd = 5'd0; in_data = '0;
      drain_en = 1'b0; fwd_addr1 = 5'd5; fwd_addr2 = 5'd6;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");

      // first push on the first edge after reset release; lookup must not
      // see the request that is being pushed this cycle
      rst = 1'b1;
      in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hA;
      #1;
      chk("first_in_ready", in_ready, 1);
      chk("lookup_excl_push", fwd_hit1, 0);
      tick();
      in_valid = 1'b0;
      #1;
      chk("first_push_occ", occupancy, 1);
      chk("no_write_drain_off", write, 0);

      // ordered drain and forwarding priority
      push_one(5'd6, 32'hB);
      push_one(5'd5, 32'hC);
      fwd_addr1 = 5'd5; fwd_addr2 = 5'd7;
      #1;
      chk("ord_occ3", occupancy, 3);
      chk("fwd_hit1_youngest", fwd_hit1, 1);
      chk("fwd_data1_youngest", fwd_data1, 32'hC);
      chk("fwd_hit2_miss", fwd_hit2, 0);
      chk("fwd_data2_miss", fwd_data2, 0);
      fwd_addr2 = 5'd6;
      #1;
      chk("fwd_hit2_6", fwd_hit2, 1);
      chk("fwd_data2_6", fwd_data2, 32'hB);
      drain_en = 1'b1;
      #1;
      chk("drain0_write", write, 1);
      chk("drain0_reg", write_reg, 5);
      chk("drain0_data", write_data, 32'hA);
      tick();
      chk("drain1_write", write, 1);
      chk("drain1_reg", write_reg, 6);
      chk("drain1_data", write_data, 32'hB);
      tick();
      chk("drain2_write", write, 1);
      chk("drain2_reg", write_reg, 5);
      chk("drain2_data", write_data, 32'hC);
      tick();
      chk("drained_write", write, 0);
      chk("drained_reg", write_reg, 0);
      chk("drained_data", write_data, 0);
      chk("drained_occ", occupancy, 0);

      // x0 discard
      in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFF; fwd_addr1 = 5'd0;
      #1;
      chk("x0_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("x0_occ", occupancy, 0);
      chk("x0_write", write, 0);
      chk("x0_hit1", fwd_hit1, 0);
      tick();
      chk("x0_write_later", write, 0);

      // head entry stays visible to lookups during its write cycle
      drain_en = 1'b0;
      push_one(5'd9, 32'h99);
      fwd_addr1 = 5'd9;
      #1;
      chk("head_hit_idle", fwd_hit1, 1);
      drain_en = 1'b1;
      #1;
      chk("head_write", write, 1);
      chk("head_write_reg", write_reg, 9);
      chk("head_hit_wr", fwd_hit1, 1);
      chk("head_data_wr", fwd_data1, 32'h99);
      tick();
      chk("head_gone_hit", fwd_hit1, 0);
      chk("head_gone_occ", occupancy, 0);

      // fill to full, stall the extra request
      drain_en = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         #1;
         chk("fill_in_ready", in_ready, 1);
         push_one(5'(i), 32'h100 + 32'(i));
         exp_q.push_back({5'(i), 32'h100 + 32'(i)});
      end
      #1;
      chk("full_in_ready", in_ready, 0);
      chk("full_occ", occupancy, DEPTH);
      req_rd = 5'd7; req_data = 32'h777; k = 0;
      in_valid = 1'b1; in_rd = req_rd; in_data = req_data;
      tick();
      chk("stall_occ", occupancy, DEPTH);
      chk("stall_in_ready", in_ready, 0);

      // continuous push + drain across pointer wrap
      drain_en = 1'b1;
      for (int c = 0; c < 3 * DEPTH; c++) begin
         #1;
         m_occ = exp_q.size();
         chk("wrap_in_ready", in_ready, (m_occ != DEPTH) ? 1 : 0);
         chk("wrap_write", write, (m_occ != 0) ? 1 : 0);
         chk("wrap_occ", occupancy, m_occ);
         if (m_occ != 0) begin
            chk("wrap_reg", write_reg, exp_q[0][36:32]);
            chk("wrap_data", write_data, exp_q[0][31:0]);
         end
         tick();
         if (m_occ != 0) void'(exp_q.pop_front());
         if (m_occ != DEPTH) begin
            exp_q.push_back({req_rd, req_data});
            k++;
            req_rd   = 5'((k % 31) + 1);
            req_data = 32'hD000 + 32'(k);
            in_rd    = req_rd;
            in_data  = req_data;
         end
      end
      in_valid = 1'b0;
      for (int c = 0; c < 2 * DEPTH; c++) begin
         #1;
         if (exp_q.size() == 0) break;
         chk("tail_write", write, 1);
         chk("tail_reg", write_reg, exp_q[0][36:32]);
         chk("tail_data", write_data, exp_q[0][31:0]);
         tick();
         void'(exp_q.pop_front());
      end
      chk("tail_drain_bound", exp_q.size(), 0);
      chk("tail_occ", occupancy, 0);
      chk("tail_write_idle", write, 0);

      // simultaneous push and pop at occupancy 2
      drain_en = 1'b0;
      push_one(5'd10, 32'hAA);
      push_one(5'd11, 32'hBB);
      #1;
      chk("pp_occ_before", occupancy, 2);
      in_valid = 1'b1; in_rd = 5'd12; in_data = 32'hCC; drain_en = 1'b1;
      #1;
      chk("pp_write", write, 1);
      chk("pp_reg", write_reg, 10);
      chk("pp_data", write_data, 32'hAA);
      tick();
      in_valid = 1'b0;
      #1;
      chk("pp_occ_after", occupancy, 2);
      chk("pp_next_reg", write_reg, 11);
      chk("pp_next_data", write_data, 32'hBB);
      tick();
      chk("pp_last_reg", write_reg, 12);
      chk("pp_last_data", write_data, 32'hCC);
      tick();
      chk("pp_empty_occ", occupancy, 0);

      // reset mid-stream, pulsed between clock edges
      drain_en = 1'b0;
      push_one(5'd3, 32'h33);
      push_one(5'd4, 32'h44);
      push_one(5'd5, 32'h55);
      fwd_addr1 = 5'd3; fwd_addr2 = 5'd5;
      #1;
      chk("mid_occ3", occupancy, 3);
      chk("mid_hit1", fwd_hit1, 1);
      drain_en = 1'b1;
      #1;
      chk("mid_write_pre", write, 1);
      rst = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      rst = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("post_reset_write", write, 0);
         chk("post_reset_occ", occupancy, 0);
      end
      push_one(5'd8, 32'h88);
      #1;
      chk("new_push_occ", occupancy, 1);
      chk("new_push_write", write, 1);
      chk("new_push_reg", write_reg, 8);
      chk("new_push_data", write_data, 32'h88);
      tick();
      chk("new_push_done", occupancy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
